// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared widths, default constants and IF/ID record for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP            = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_EXC_VECTOR = 32'h0000_0100;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;

endpackage
`default_nettype wire

// File: rtl/ifid_register.sv
`default_nettype none
// ============================================================================
// Module   : ifid_register
// Brief    : IF/ID pipeline register with reset > kill > stall > capture priority.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_register
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            kill,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc4_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc4_out,
  output logic            valid_out
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  // A killed entry keeps its pc/pc4 so downstream sees the last known address.
  always_comb begin
    ifid_d = ifid_q;
    if (kill) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end else if (!stall) begin
      ifid_d.instr = instr_in;
      ifid_d.pc    = pc_in;
      ifid_d.pc4   = pc4_in;
      ifid_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc    <= RESET_PC;
      ifid_q.pc4   <= RESET_PC + PC_STEP;
      ifid_q.valid <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign instr_out = ifid_q.instr;
  assign pc_out    = ifid_q.pc;
  assign pc4_out   = ifid_q.pc4;
  assign valid_out = ifid_q.valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Program counter, next-PC selection and IF/ID capture.
//            Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR  = DEFAULT_NOP_INSTR,
  parameter logic [XLEN-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_out,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic            ifid_valid,
  output logic            exc_misalign
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic exc_q;
  logic exc_d;
  logic misaligned;

  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    pc_d  = pc_q;
    exc_d = 1'b0;
    if (redirect) begin
      if (misaligned) begin
        pc_d  = EXC_VECTOR;
        exc_d = 1'b1;
      end else begin
        pc_d = redirect_pc;
      end
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  // Pulse is registered so it lines up with the vector appearing on pc_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  assign exc_misalign = exc_q;
  logic unused_exc_vector_en;
  assign unused_exc_vector_en = 1'b0;
`else
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign exc_misalign        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

  ifid_register #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_register (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .kill      (redirect | flush),
    .instr_in  (instr_in),
    .pc_in     (pc_q),
    .pc4_in    (pc_plus4),
    .instr_out (ifid_instr),
    .pc_out    (ifid_pc),
    .pc4_out   (ifid_pc4),
    .valid_out (ifid_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed + randomized self-checking bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] T_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] T_NOP        = 32'h0000_0000;
  localparam logic [31:0] T_EXC_VECTOR = 32'h0000_0100;
  localparam logic [31:0] MEM_TAG      = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        exc_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what each output should read after the last edge.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  logic        m_valid;
  logic        m_exc;

  always #5 clk = ~clk;

  // Instruction memory: combinational, word tagged so it differs from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ MEM_TAG;
  endfunction

  assign instr_in = mem_word(pc_out);

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc_out       (pc_out),
    .instr_in     (instr_in),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .exc_misalign (exc_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_out", pc_out, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc4", ifid_pc4, m_ipc4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("exc_misalign", {31'b0, exc_misalign}, {31'b0, m_exc});
  endtask

  // Apply one cycle of controls, advance the model by the stage's rules, then compare.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic rd, input logic [31:0] rpc);
    logic [31:0] old_pc;
    reset = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    old_pc = m_pc;
    if (r) begin
      m_pc = T_RESET_PC; m_instr = T_NOP; m_ipc = T_RESET_PC;
      m_ipc4 = T_RESET_PC + 32'd4; m_valid = 1'b0; m_exc = 1'b0;
    end else begin
      if (rd || f) begin
        m_instr = T_NOP; m_valid = 1'b0;
      end else if (!s) begin
        m_instr = mem_word(old_pc); m_ipc = old_pc;
        m_ipc4 = old_pc + 32'd4; m_valid = 1'b1;
      end
      m_exc = 1'b0;
      if (rd) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (rpc % 4 != 0) begin
          m_pc = T_EXC_VECTOR; m_exc = 1'b1;
        end else begin
          m_pc = rpc;
        end
`else
        m_pc = rpc - (rpc % 4);
`endif
      end else if (!s) begin
        m_pc = old_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    m_pc = 'x; m_instr = 'x; m_ipc = 'x; m_ipc4 = 'x; m_valid = 'x; m_exc = 'x;
    @(posedge clk);
    #1;
    // Reset and free-run from 0.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Stall three cycles with PC at 8.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Redirect with simultaneous stall, then two edges to see the target valid.
    step(0, 1, 0, 1, 32'h0000_0040);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Flush alone, and flush with stall.
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Wrap at the top of the address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Misaligned redirect.
    step(0, 0, 0, 1, 32'h0000_0042);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Reset asserted mid-stream, then resume.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Randomized controls.
    for (int i = 0; i < 400; i++) begin
      logic r, s, f, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      step(r, s, f, rd, rpc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the processor: holds the program counter, drives the word-aligned byte address into the instruction memory, and captures the returned word into the IF/ID pipeline register. It sits directly upstream of the instruction memory, which returns `RD` combinationally from `A`. It sits directly downstream of the branch/jump resolution logic, which supplies redirects and stall/flush requests.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000, instruction word injected into IF/ID on flush/redirect (`sll $0,$0,0`).
- `EXC_VECTOR`, 32'h0000_0100, PC loaded on a misaligned redirect (only with `FETCH_MISALIGN_TRAP_EN`).

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID contents.
- `flush`  in  1  invalidate IF/ID on the next edge.
- `redirect`  in  1  load `redirect_pc` into PC.
- `redirect_pc`  in  32  branch/jump target byte address.
- `pc_out`  out  32  current PC; drives instruction memory `A`.
- `instr_in`  in  32  instruction word from instruction memory `RD`.
- `ifid_instr`  out  32  registered instruction.
- `ifid_pc`  out  32  registered PC of `ifid_instr`.
- `ifid_pc4`  out  32  registered `ifid_pc + 4`.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `exc_misalign`  out  1  one-cycle pulse on a trapped redirect (only with `FETCH_MISALIGN_TRAP_EN`; tied 0 otherwise).

## Operation
- PC register, next-PC priority per edge:
  1. `reset`: `RESET_PC`.
  2. `redirect`: `redirect_pc`.
  3. `stall`: hold.
  4. Otherwise: PC + 4.
- PC + 4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- IF/ID priority per edge:
  1. `reset`: `ifid_instr`=`NOP_INSTR`, `ifid_pc`=`RESET_PC`, `ifid_pc4`=`RESET_PC+4`, `ifid_valid`=0.
  2. `redirect` or `flush`: `ifid_instr`=`NOP_INSTR`, `ifid_valid`=0; `ifid_pc` and `ifid_pc4` hold.
  3. `stall`: all IF/ID fields hold.
  4. Otherwise: capture `instr_in`, `pc_out`, `pc_out+4`, and set `ifid_valid`=1.
- Simultaneous events:
  - `redirect` and `stall`: redirect wins on both PC and IF/ID.
  - `flush` and `stall`: PC holds and IF/ID is invalidated.
  - `flush` alone: PC advances normally.
- Reset asserted mid-stream: everything is discarded on that edge. The first valid fetch is captured on the edge after reset deasserts.
- Address range checks are not performed here; the instruction memory owns depth decoding.

## Timing
- `pc_out` is a direct register output; it never depends combinationally on any input.
- Fetch latency is 1 cycle: the PC value present in cycle N appears with its instruction in IF/ID after edge N+1.
- Redirect penalty is 1 bubble: the target's instruction appears in IF/ID 2 edges after `redirect` is sampled.
- `stall` is level-sensitive; each stalled cycle costs exactly one cycle with no lost or duplicated fetch.
- Reset values of all outputs:
  - `pc_out` = `RESET_PC`
  - `ifid_instr` = `NOP_INSTR`
  - `ifid_pc` = `RESET_PC`
  - `ifid_pc4` = `RESET_PC+4`
  - `ifid_valid` = 0
  - `exc_misalign` = 0

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: a redirect with `redirect_pc[1:0]` != 0 loads `EXC_VECTOR` instead of the target. `exc_misalign` is registered and pulses high for exactly one cycle, aligned with the new PC. IF/ID is invalidated as for a normal redirect.
- `FETCH_MISALIGN_TRAP_EN` undefined: `redirect_pc[1:0]` is forced to 2'b00 on load and `exc_misalign` is tied 0.

## Structure
- Shared package `fetch_pkg`: `XLEN`=32, `PC_STEP`=4, default `RESET_PC`/`NOP_INSTR`/`EXC_VECTOR` constants, and a packed `ifid_t` struct {instr, pc, pc4, valid}.
- One sub-module, `ifid_register`: the IF/ID register with stall/flush/reset priority. The PC and next-PC logic stay in `fetch_stage`.

## Test plan
- Reset, then 4 free-running cycles with memory returning word = address -> `pc_out` 0,4,8,C,10; `ifid_pc` lags by one edge; `ifid_valid` rises on the first post-reset edge.
- `stall` high for 3 cycles at PC=8 -> `pc_out` holds 8 and IF/ID holds the instruction from PC=4; fetch resumes at C with no skipped address.
- `redirect` to 32'h40 with `stall` also high -> next `pc_out`=40 and `ifid_valid`=0 for one cycle; the instruction from 40 becomes valid 2 edges after redirect.
- `flush` alone at PC=10 -> `ifid_valid`=0 and `ifid_instr`=`NOP_INSTR`; `pc_out` advances to 14.
- `redirect` to 32'hFFFF_FFFC, then run -> `pc_out` wraps to 0 and `ifid_pc4`=0 for that entry.
- `redirect` to 32'h42:
  - With `FETCH_MISALIGN_TRAP_EN`: `pc_out`=`EXC_VECTOR` and a 1-cycle `exc_misalign` pulse.
  - Without it: `pc_out`=32'h40 and `exc_misalign` stays 0.
